distram_port_arbiter: RTL and testbench
=======================================

# distram_port_arbiter

Shares one 2-read/1-write distributed RAM among NUM_RREQ read requesters and NUM_WREQ write requesters. Each cycle it grants up to two reads (one per RAM read port) and one write, using independent round-robin schemes. It returns read data one cycle later through registered per-requester responses. After every reset it zero-clears the whole RAM before accepting any request.

## Interface
- INNER_WIDTH, 32, data width of one RAM entry
- OUTER_WIDTH, 32, number of RAM entries (power of two); IDX = $clog2(OUTER_WIDTH)
- NUM_RREQ, 4, number of read requesters (≥2)
- NUM_WREQ, 2, number of write requesters (≥1)
- CLK  in  1  single clock; all state updates on posedge
- nRST  in  1  synchronous active-low reset
- rreq_valid  in  [NUM_RREQ]  read request valid
- rreq_index  in  [NUM_RREQ][IDX]  read index per requester
- rreq_ready  out  [NUM_RREQ]  read grant, combinational, same cycle
- rresp_valid  out  [NUM_RREQ]  registered read response valid
- rresp_data  out  [NUM_RREQ][INNER_WIDTH]  registered read data
- wreq_valid  in  [NUM_WREQ]  write request valid
- wreq_index  in  [NUM_WREQ][IDX]  write index per requester
- wreq_data  in  [NUM_WREQ][INNER_WIDTH]  write data per requester
- wreq_ready  out  [NUM_WREQ]  write grant, combinational
- busy  out  1  high while clearing
- ram_port0_rindex, ram_port1_rindex  out  IDX  RAM read indices
- ram_port0_rdata, ram_port1_rdata  in  INNER_WIDTH  RAM async read data
- ram_wen  out  1; ram_windex  out  IDX; ram_wdata  out  INNER_WIDTH  RAM write port

## Operation
- FSM has two states: CLEAR and RUN. Reset enters CLEAR with clear_ptr=0.
- CLEAR:
  - Each cycle drives ram_wen=1, ram_windex=clear_ptr, ram_wdata=0, then increments clear_ptr.
  - After the write at clear_ptr=OUTER_WIDTH-1, the next state is RUN.
  - All rreq_ready and wreq_ready are 0, and busy=1.
- RUN: busy=0.
- Read arbitration:
  - Scan requesters in order rr_rptr, rr_rptr+1, … (mod NUM_RREQ).
  - The first valid requester is granted RAM port 0; the second valid requester is granted port 1.
  - All other requesters get ready=0. Unused ports drive index 0.
  - rr_rptr becomes (last granted requester + 1) mod NUM_RREQ. It is unchanged if there were no grants.
- Read response:
  - For each requester granted in cycle N, rresp_valid=1 in cycle N+1 with rresp_data = the RAM rdata sampled at the cycle-N edge from that requester's port.
  - An ungranted requester has rresp_valid=0 the next cycle. rresp_data holds its last value.
- Write arbitration:
  - Single round-robin among wreq_valid starting at rr_wptr.
  - The winner drives ram_wen=1, ram_windex and ram_wdata. rr_wptr becomes winner+1 mod NUM_WREQ.
  - With no valid write request, ram_wen=0.
- Hazards:
  - A read and a write to the same index granted in the same cycle return the OLD data; no bypass.
  - A read granted in the cycle after the write returns the new data.
- Requesters hold valid and payload until ready. The arbiter does not require that valid is stable.

## Timing
- Reset values, forced while nRST=0 at the edge:
  - state=CLEAR, clear_ptr=0, rr_rptr=0, rr_wptr=0
  - rresp_valid=0, rresp_data=0
- Outputs while nRST is low: ram_wen=0, all ready=0, busy=1.
- Clear takes exactly OUTER_WIDTH cycles after the first cycle with nRST=1. The first grant is possible in cycle OUTER_WIDTH+1.
- Read latency is 1 cycle, grant to rresp_valid. Sustained throughput is 2 reads + 1 write per cycle.
- Reset asserted mid-clear or mid-RUN:
  - Pending responses are dropped (rresp_valid=0 the next cycle).
  - The clear restarts from index 0.
- A requester that is granted every cycle receives back-to-back responses.
- Round-robin fairness: any continuously valid read requester is granted within ceil(NUM_RREQ/2) RUN cycles. Any continuously valid write requester is granted within NUM_WREQ cycles.

## Test plan
- Clear after reset: release nRST with defaults.
  - ram_wen=1 for 32 consecutive cycles with windex 0..31 and wdata=0, busy=1.
  - Cycle 33: busy=0.
  - A read of any index then returns 0.
- Read round-robin: rreq_valid=4'b1111 held constant, rr_rptr=0.
  - Grants are {0,1}, then {2,3}, then {0,1}.
  - Each granted requester gets rresp_valid exactly one cycle after its grant.
- Write then read: W0 writes index 5 = 0xDEADBEEF in cycle N; requester 2 reads index 5 in cycle N+1.
  - rresp_data[2]=0xDEADBEEF in cycle N+2.
- Same-cycle hazard: write index 7 = 0x1234 and read index 7 in the same cycle, after clear.
  - rresp_data=0x0. A re-read the next cycle returns 0x1234.
- Write contention: both write requesters valid for 4 cycles.
  - Grants alternate W0, W1, W0, W1, and only the winner's data reaches ram_wdata.
- Reset mid-operation: assert nRST for 1 cycle at clear_ptr=10, then again while read grants are outstanding.
  - Clear restarts at index 0.
  - rresp_valid=0 after reset.
  - rr pointers return to 0.

Source files
------------

// File: rtl/distram_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals for distram_port_arbiter.
// Latency: none, wires only. Backpressure: rreq_ready/wreq_ready are same-cycle grants.
// Ports: slave = arbiter view (takes requests, drives grants, responses and RAM controls);
//        master = requester/RAM view (drives requests and RAM read data).
interface distram_port_arbiter_if #(
  parameter int INNER_WIDTH = 32,
  parameter int OUTER_WIDTH = 32,
  parameter int NUM_RREQ    = 4,
  parameter int NUM_WREQ    = 2
);
  localparam int IDX = $clog2(OUTER_WIDTH);

  logic [NUM_RREQ-1:0]                  rreq_valid;
  logic [NUM_RREQ-1:0][IDX-1:0]         rreq_index;
  logic [NUM_RREQ-1:0]                  rreq_ready;
  logic [NUM_RREQ-1:0]                  rresp_valid;
  logic [NUM_RREQ-1:0][INNER_WIDTH-1:0] rresp_data;

  logic [NUM_WREQ-1:0]                  wreq_valid;
  logic [NUM_WREQ-1:0][IDX-1:0]         wreq_index;
  logic [NUM_WREQ-1:0][INNER_WIDTH-1:0] wreq_data;
  logic [NUM_WREQ-1:0]                  wreq_ready;

  logic                                 busy;

  logic [IDX-1:0]                       ram_port0_rindex;
  logic [IDX-1:0]                       ram_port1_rindex;
  logic [INNER_WIDTH-1:0]               ram_port0_rdata;
  logic [INNER_WIDTH-1:0]               ram_port1_rdata;
  logic                                 ram_wen;
  logic [IDX-1:0]                       ram_windex;
  logic [INNER_WIDTH-1:0]               ram_wdata;

  modport slave (
    input  rreq_valid, rreq_index, wreq_valid, wreq_index, wreq_data,
           ram_port0_rdata, ram_port1_rdata,
    output rreq_ready, rresp_valid, rresp_data, wreq_ready, busy,
           ram_port0_rindex, ram_port1_rindex, ram_wen, ram_windex, ram_wdata
  );

  modport master (
    output rreq_valid, rreq_index, wreq_valid, wreq_index, wreq_data,
           ram_port0_rdata, ram_port1_rdata,
    input  rreq_ready, rresp_valid, rresp_data, wreq_ready, busy,
           ram_port0_rindex, ram_port1_rindex, ram_wen, ram_windex, ram_wdata
  );
endinterface

// File: rtl/distram_port_arbiter.sv
// Shares a 2R/1W distributed RAM: up to two round-robin read grants plus one write grant per cycle.
// Latency: grants are combinational; read data returns registered one cycle after the grant.
// Backpressure: requesters wait on rreq_ready/wreq_ready; nothing is granted while busy clearing.
// Ports: CLK, nRST (synchronous, active low) and bus (slave modport of distram_port_arbiter_if).
module distram_port_arbiter #(
  parameter int INNER_WIDTH = 32,
  parameter int OUTER_WIDTH = 32,
  parameter int NUM_RREQ    = 4,
  parameter int NUM_WREQ    = 2
) (
  input logic                   CLK,
  input logic                   nRST,
  distram_port_arbiter_if.slave bus
);
  localparam int IDX = $clog2(OUTER_WIDTH);
  localparam int RPW = $clog2(NUM_RREQ);
  localparam int WPW = (NUM_WREQ > 1) ? $clog2(NUM_WREQ) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                               state;
  logic [IDX-1:0]                       clear_ptr;
  logic [RPW-1:0]                       rr_rptr;
  logic [WPW-1:0]                       rr_wptr;
  logic [NUM_RREQ-1:0]                  rresp_valid_q;
  logic [NUM_RREQ-1:0][INNER_WIDTH-1:0] rresp_data_q;

  // Grants are only issued in RUN, and the reset cycle itself is treated as not running.
  logic run;
  assign run = nRST && (state == RUN);

  function automatic logic [RPW-1:0] rinc(input logic [RPW-1:0] p);
    if (p == RPW'(NUM_RREQ - 1)) return '0;
    return p + RPW'(1);
  endfunction

  function automatic logic [WPW-1:0] winc(input logic [WPW-1:0] p);
    if (p == WPW'(NUM_WREQ - 1)) return '0;
    return p + WPW'(1);
  endfunction

  // Read scan from rr_rptr: first valid requester takes port 0, second takes port 1.
  logic           g0_vld, g1_vld;
  logic [RPW-1:0] g0_sel, g1_sel;

  always_comb begin
    int r;
    r      = 0;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_sel = '0;
    g1_sel = '0;
    if (run) begin
      for (int k = 0; k < NUM_RREQ; k++) begin
        r = (int'(rr_rptr) + k) % NUM_RREQ;
        if (bus.rreq_valid[r]) begin
          if (!g0_vld) begin
            g0_vld = 1'b1;
            g0_sel = RPW'(r);
          end else if (!g1_vld) begin
            g1_vld = 1'b1;
            g1_sel = RPW'(r);
          end
        end
      end
    end
  end

  // Single write winner from rr_wptr.
  logic           w_vld;
  logic [WPW-1:0] w_sel;

  always_comb begin
    int w;
    w     = 0;
    w_vld = 1'b0;
    w_sel = '0;
    if (run) begin
      for (int k = 0; k < NUM_WREQ; k++) begin
        w = (int'(rr_wptr) + k) % NUM_WREQ;
        if (bus.wreq_valid[w] && !w_vld) begin
          w_vld = 1'b1;
          w_sel = WPW'(w);
        end
      end
    end
  end

  logic [NUM_RREQ-1:0] rreq_ready_c;
  logic [NUM_WREQ-1:0] wreq_ready_c;

  always_comb begin
    rreq_ready_c = '0;
    wreq_ready_c = '0;
    if (g0_vld) rreq_ready_c[g0_sel] = 1'b1;
    if (g1_vld) rreq_ready_c[g1_sel] = 1'b1;
    if (w_vld)  wreq_ready_c[w_sel]  = 1'b1;
  end

  // RAM write port is owned by the clear sweep in CLEAR and by the write winner in RUN.
  logic                   ram_wen_c;
  logic [IDX-1:0]         ram_windex_c;
  logic [INNER_WIDTH-1:0] ram_wdata_c;

  always_comb begin
    ram_wen_c    = 1'b0;
    ram_windex_c = '0;
    ram_wdata_c  = '0;
    if (nRST && (state == CLEAR)) begin
      ram_wen_c    = 1'b1;
      ram_windex_c = clear_ptr;
    end else if (w_vld) begin
      ram_wen_c    = 1'b1;
      ram_windex_c = bus.wreq_index[w_sel];
      ram_wdata_c  = bus.wreq_data[w_sel];
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state         <= CLEAR;
      clear_ptr     <= '0;
      rr_rptr       <= '0;
      rr_wptr       <= '0;
      rresp_valid_q <= '0;
      rresp_data_q  <= '0;
    end else begin
      rresp_valid_q <= rreq_ready_c;
      case (state)
        CLEAR: begin
          clear_ptr <= clear_ptr + IDX'(1);
          if (clear_ptr == IDX'(OUTER_WIDTH - 1)) state <= RUN;
        end
        RUN: begin
          // Pointer moves past the last requester served this cycle.
          if (g1_vld)      rr_rptr <= rinc(g1_sel);
          else if (g0_vld) rr_rptr <= rinc(g0_sel);
          if (w_vld)       rr_wptr <= winc(w_sel);
          // RAM reads are asynchronous, so the data captured here predates this cycle's write.
          if (g0_vld) rresp_data_q[g0_sel] <= bus.ram_port0_rdata;
          if (g1_vld) rresp_data_q[g1_sel] <= bus.ram_port1_rdata;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.rreq_ready       = rreq_ready_c;
  assign bus.wreq_ready       = wreq_ready_c;
  assign bus.rresp_valid      = rresp_valid_q;
  assign bus.rresp_data       = rresp_data_q;
  assign bus.busy             = !run;
  assign bus.ram_port0_rindex = g0_vld ? bus.rreq_index[g0_sel] : '0;
  assign bus.ram_port1_rindex = g1_vld ? bus.rreq_index[g1_sel] : '0;
  assign bus.ram_wen          = ram_wen_c;
  assign bus.ram_windex       = ram_windex_c;
  assign bus.ram_wdata        = ram_wdata_c;
endmodule

// File: tb/tb_distram_port_arbiter.sv
// Bench for distram_port_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: model predicts grants per cycle and responses one cycle later.
// Backpressure: requests are re-randomized every cycle; the arbiter must cope with unstable valid.
module tb_distram_port_arbiter;
  localparam int IW  = 32;
  localparam int OW  = 32;
  localparam int NR  = 4;
  localparam int NW  = 2;
  localparam int IDX = 5;

  logic CLK = 1'b0;
  logic nRST;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  distram_port_arbiter_if #(.INNER_WIDTH(IW), .OUTER_WIDTH(OW), .NUM_RREQ(NR), .NUM_WREQ(NW)) bus();

  distram_port_arbiter #(.INNER_WIDTH(IW), .OUTER_WIDTH(OW), .NUM_RREQ(NR), .NUM_WREQ(NW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // RAM: asynchronous reads, synchronous write; starts non-zero so the clear sweep matters.
  logic [IW-1:0] ram [OW] = '{default: 32'hA5A5_5A5A};
  always @(posedge CLK) if (bus.ram_wen) ram[bus.ram_windex] <= bus.ram_wdata;
  assign bus.ram_port0_rdata = ram[bus.ram_port0_rindex];
  assign bus.ram_port1_rdata = ram[bus.ram_port1_rindex];

  // Reference model state.
  logic [IW-1:0] ref_mem [OW] = '{default: 32'hA5A5_5A5A};
  int            clr_idx;
  int            rptr, wptr;
  logic [NR-1:0] exp_rvalid;
  logic [IW-1:0] exp_rdata [NR];

  // Values seen in the most recent step, for directed checks.
  logic [NR-1:0]  obs_rrdy;
  logic [NW-1:0]  obs_wrdy;
  logic [IW-1:0]  obs_wdat;
  logic [IDX-1:0] obs_widx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clr_idx    = 0;
    rptr       = 0;
    wptr       = 0;
    exp_rvalid = '0;
    for (int i = 0; i < NR; i++) exp_rdata[i] = '0;
  endtask

  task automatic set_idle();
    bus.rreq_valid = '0;
    bus.wreq_valid = '0;
    for (int i = 0; i < NR; i++) bus.rreq_index[i] = '0;
    for (int i = 0; i < NW; i++) begin
      bus.wreq_index[i] = '0;
      bus.wreq_data[i]  = '0;
    end
  endtask

  task automatic rand_inputs();
    bus.rreq_valid = NR'($urandom);
    bus.wreq_valid = NW'($urandom);
    for (int i = 0; i < NR; i++) bus.rreq_index[i] = IDX'($urandom_range(0, 7));
    for (int i = 0; i < NW; i++) begin
      bus.wreq_index[i] = IDX'($urandom_range(0, 7));
      bus.wreq_data[i]  = $urandom;
    end
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    int             gr[$];
    int             ww;
    logic [NR-1:0]  e_rrdy;
    logic [NW-1:0]  e_wrdy;
    logic           e_wen, clearing, running;
    logic [IDX-1:0] e_widx, e_p0, e_p1;
    logic [IW-1:0]  e_wdat;
    @(negedge CLK);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rresp_valid[%0d]", i), 64'(bus.rresp_valid[i]), 64'(exp_rvalid[i]));
      chk($sformatf("rresp_data[%0d]", i), 64'(bus.rresp_data[i]), 64'(exp_rdata[i]));
    end
    e_rrdy = '0; e_wrdy = '0; e_wen = 1'b0; e_widx = '0; e_wdat = '0; e_p0 = '0; e_p1 = '0;
    ww = -1;
    clearing = (clr_idx < OW);
    running  = nRST && !clearing;
    if (nRST && clearing) begin
      e_wen  = 1'b1;
      e_widx = IDX'(clr_idx);
    end else if (running) begin
      for (int k = 0; k < NR; k++)
        if (bus.rreq_valid[(rptr + k) % NR] && gr.size() < 2) gr.push_back((rptr + k) % NR);
      for (int k = 0; k < NW; k++)
        if (bus.wreq_valid[(wptr + k) % NW] && ww < 0) ww = (wptr + k) % NW;
      foreach (gr[j]) e_rrdy[gr[j]] = 1'b1;
      if (gr.size() > 0) e_p0 = bus.rreq_index[gr[0]];
      if (gr.size() > 1) e_p1 = bus.rreq_index[gr[1]];
      if (ww >= 0) begin
        e_wrdy[ww] = 1'b1;
        e_wen      = 1'b1;
        e_widx     = bus.wreq_index[ww];
        e_wdat     = bus.wreq_data[ww];
      end
    end
    chk("busy", 64'(bus.busy), 64'(!running));
    chk("rreq_ready", 64'(bus.rreq_ready), 64'(e_rrdy));
    chk("wreq_ready", 64'(bus.wreq_ready), 64'(e_wrdy));
    chk("ram_wen", 64'(bus.ram_wen), 64'(e_wen));
    if (e_wen) begin
      chk("ram_windex", 64'(bus.ram_windex), 64'(e_widx));
      chk("ram_wdata", 64'(bus.ram_wdata), 64'(e_wdat));
    end
    if (running) begin
      chk("ram_port0_rindex", 64'(bus.ram_port0_rindex), 64'(e_p0));
      chk("ram_port1_rindex", 64'(bus.ram_port1_rindex), 64'(e_p1));
    end
    obs_rrdy = bus.rreq_ready;
    obs_wrdy = bus.wreq_ready;
    obs_wdat = bus.ram_wdata;
    obs_widx = bus.ram_windex;
    @(posedge CLK);
    if (!nRST) begin
      model_reset();
    end else if (clearing) begin
      ref_mem[clr_idx] = '0;
      clr_idx++;
      exp_rvalid = '0;
    end else begin
      exp_rvalid = '0;
      foreach (gr[j]) begin
        exp_rvalid[gr[j]] = 1'b1;
        exp_rdata[gr[j]]  = ref_mem[bus.rreq_index[gr[j]]];
      end
      if (gr.size() > 0) rptr = (gr[gr.size() - 1] + 1) % NR;
      if (ww >= 0) begin
        ref_mem[bus.wreq_index[ww]] = bus.wreq_data[ww];
        wptr = (ww + 1) % NW;
      end
    end
    #1;
  endtask

  logic [NW-1:0] w_alt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [IW-1:0] d_alt [4] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hA0A0_0000, 32'hB1B1_1111};
  logic [NR-1:0] r_alt [3] = '{4'b0011, 4'b1100, 4'b0011};

  initial begin
    nRST = 1'b0;
    set_idle();
    @(posedge CLK); #1;
    model_reset();

    // Reset held with requests present: nothing granted, RAM untouched.
    bus.rreq_valid = '1;
    bus.wreq_valid = '1;
    step();

    // Clear sweep: 32 write cycles of zero, requests ignored throughout.
    nRST = 1'b1;
    for (int c = 0; c < OW; c++) begin
      rand_inputs();
      step();
    end
    chk("busy_after_clear", 64'(bus.busy), 64'(0));

    // Read round robin with all four requesters valid; every read returns cleared zero.
    set_idle();
    bus.rreq_valid = 4'b1111;
    for (int i = 0; i < NR; i++) bus.rreq_index[i] = IDX'(i * 7 + 3);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rr_grant", 64'(obs_rrdy), 64'(r_alt[c]));
      chk("rr_resp_valid", 64'(bus.rresp_valid), 64'(r_alt[c]));
    end
    chk("clear_read_zero", 64'(bus.rresp_data[1]), 64'(0));

    // Write then read one cycle later sees the new value.
    set_idle();
    bus.wreq_valid    = 2'b01;
    bus.wreq_index[0] = 5'd5;
    bus.wreq_data[0]  = 32'hDEAD_BEEF;
    step();
    set_idle();
    bus.rreq_valid    = 4'b0100;
    bus.rreq_index[2] = 5'd5;
    step();
    chk("wr_rd_valid", 64'(bus.rresp_valid[2]), 64'(1));
    chk("wr_rd_data", 64'(bus.rresp_data[2]), 64'(32'hDEAD_BEEF));

    // Same-cycle read/write to one index returns old data; the next read sees the new value.
    set_idle();
    bus.wreq_valid    = 2'b10;
    bus.wreq_index[1] = 5'd7;
    bus.wreq_data[1]  = 32'h1234;
    bus.rreq_valid    = 4'b0001;
    bus.rreq_index[0] = 5'd7;
    step();
    chk("hazard_old", 64'(bus.rresp_data[0]), 64'(0));
    bus.wreq_valid = 2'b00;
    step();
    chk("hazard_new", 64'(bus.rresp_data[0]), 64'(32'h1234));

    // Write contention alternates W0, W1 and only the winner's data is written.
    set_idle();
    bus.wreq_valid    = 2'b11;
    bus.wreq_index[0] = 5'd20;
    bus.wreq_data[0]  = 32'hA0A0_0000;
    bus.wreq_index[1] = 5'd21;
    bus.wreq_data[1]  = 32'hB1B1_1111;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("wr_alt_grant", 64'(obs_wrdy), 64'(w_alt[c]));
      chk("wr_alt_data", 64'(obs_wdat), 64'(d_alt[c]));
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      step();
    end

    // Reset mid-clear at clear_ptr=10: sweep restarts from index 0.
    set_idle();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    for (int c = 0; c < 10; c++) step();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    step();
    chk("clear_restart_idx", 64'(obs_widx), 64'(0));
    for (int c = 1; c < OW; c++) step();

    // Reset while read responses are outstanding: they are dropped and pointers return to 0.
    bus.rreq_valid = 4'b1111;
    bus.wreq_valid = 2'b11;
    step();
    chk("pre_reset_grant", 64'(obs_rrdy), 64'(4'b0011));
    nRST = 1'b0;
    step();
    chk("resp_dropped", 64'(bus.rresp_valid), 64'(0));
    nRST = 1'b1;
    for (int c = 0; c < OW; c++) step();
    step();
    chk("rptr_after_reset", 64'(obs_rrdy), 64'(4'b0011));
    chk("wptr_after_reset", 64'(obs_wrdy), 64'(2'b01));
    set_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
